// File: rtl/sys_div.sv
// sys_div: sequential restoring divider, receive side of the multiply-add stage.
// Recovers quotient A1 and remainder C1 from DATA_IN = B1*A1 + C1, one quotient
// bit per clock, with valid/ready handshakes on both sides.
// Optional feature macro: SYSDIV_CHECK_EN enables divide-by-zero / quotient-overflow
// detection with a one-cycle fast path; without it DZ and OVF are tied to 0.

package SysVerParam;
   localparam int P = 8;
endpackage

module sys_div #(
   parameter int P = SysVerParam::P
) (
   input  logic           C,
   input  logic           nR,
   input  logic           IN_VALID,
   output logic           IN_READY,
   input  logic [2*P-1:0] DATA_IN,
   input  logic [P-1:0]   B1,
   output logic           OUT_VALID,
   input  logic           OUT_READY,
   output logic [P-1:0]   A1,
   output logic [P-1:0]   C1,
   output logic           DZ,
   output logic           OVF
);

   localparam int CW = (P > 1) ? $clog2(P) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(P - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state_reg;
   state_t        state_next;
   // Partial remainder between steps; always < divisor, so P bits hold it.
   logic [P-1:0]  rem_reg;
   // Low dividend half; its MSB feeds each step and quotient bits enter at the LSB,
   // so after P steps it holds the quotient.
   logic [P-1:0]  lo_reg;
   logic [P-1:0]  div_reg;
   logic [CW-1:0] cnt_reg;
   logic [P-1:0]  a1_reg;
   logic [P-1:0]  c1_reg;

   logic          accept;
   logic          err_fast;
   logic [P:0]    rem_shift;
   logic [P-1:0]  trial;
   logic          q_bit;
   logic [P-1:0]  rem_new;

   assign accept = (state_reg == IDLE) && IN_VALID;

`ifdef SYSDIV_CHECK_EN
   logic dz_reg;
   logic ovf_reg;
   // B1 == 0 also satisfies hi >= B1, so a single compare covers both error kinds.
   assign err_fast = (DATA_IN[2*P-1:P] >= B1);
`else
   assign err_fast = 1'b0;
`endif

   // One restoring step: (P+1)-bit shifted remainder, trial subtract, restore on borrow.
   // The subtraction is kept to P bits because a kept result is always < divisor.
   always_comb begin
      rem_shift = {rem_reg, lo_reg[P-1]};
      q_bit     = (rem_shift >= {1'b0, div_reg});
      trial     = rem_shift[P-1:0] - div_reg;
      rem_new   = q_bit ? trial : rem_shift[P-1:0];
   end

   // State register.
   always_ff @(posedge C or negedge nR) begin
      if (!nR) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (IN_VALID) state_next = err_fast ? DONE : CALC;
         CALC: if (cnt_reg == LAST_STEP) state_next = DONE;
         DONE: if (OUT_READY) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      IN_READY  = (state_reg == IDLE);
      OUT_VALID = (state_reg == DONE);
   end

   // Datapath: operand capture, iteration, and result registers (held across DONE->IDLE).
   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         rem_reg <= '0;
         lo_reg  <= '0;
         div_reg <= '0;
         cnt_reg <= '0;
         a1_reg  <= '0;
         c1_reg  <= '0;
      end else if (accept) begin
         rem_reg <= DATA_IN[2*P-1:P];
         lo_reg  <= DATA_IN[P-1:0];
         div_reg <= B1;
         cnt_reg <= '0;
`ifdef SYSDIV_CHECK_EN
         if (B1 == '0) begin
            a1_reg <= '1;
            c1_reg <= DATA_IN[P-1:0];
         end else if (err_fast) begin
            a1_reg <= '1;
            c1_reg <= '0;
         end
`endif
      end else if (state_reg == CALC) begin
         rem_reg <= rem_new;
         lo_reg  <= {lo_reg[P-2:0], q_bit};
         cnt_reg <= cnt_reg + CW'(1);
         if (cnt_reg == LAST_STEP) begin
            a1_reg <= {lo_reg[P-2:0], q_bit};
            c1_reg <= rem_new;
         end
      end
   end

`ifdef SYSDIV_CHECK_EN
   // Error flags: set on a fast-path accept, cleared when the result is taken.
   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         dz_reg  <= 1'b0;
         ovf_reg <= 1'b0;
      end else if (accept) begin
         dz_reg  <= (B1 == '0);
         ovf_reg <= (B1 != '0) && err_fast;
      end else if ((state_reg == DONE) && OUT_READY) begin
         dz_reg  <= 1'b0;
         ovf_reg <= 1'b0;
      end
   end
   assign DZ  = dz_reg;
   assign OVF = ovf_reg;
`else
   assign DZ  = 1'b0;
   assign OVF = 1'b0;
`endif

   assign A1 = a1_reg;
   assign C1 = c1_reg;

endmodule

// File: tb/tb_sys_div.sv
// tb_sys_div: randomized self-checking bench for sys_div against an arithmetic
// reference (quotient = DATA_IN / B1, remainder = DATA_IN % B1, error rules).
module tb_sys_div;

   localparam int P = SysVerParam::P;

   logic           C = 1'b0;
   logic           nR = 1'b0;
   logic           IN_VALID = 1'b0;
   logic           IN_READY;
   logic [2*P-1:0] DATA_IN = '0;
   logic [P-1:0]   B1 = '0;
   logic           OUT_VALID;
   logic           OUT_READY = 1'b0;
   logic [P-1:0]   A1;
   logic [P-1:0]   C1;
   logic           DZ;
   logic           OVF;

   int checks = 0;
   int failures = 0;

   logic [P-1:0] exp_a;
   logic [P-1:0] exp_c;

   sys_div #(.P(P)) dut (
      .C(C), .nR(nR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .DATA_IN(DATA_IN), .B1(B1), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .A1(A1), .C1(C1), .DZ(DZ), .OVF(OVF)
   );

   always #5 C = ~C;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation (called #1 after a rising edge), wait for the result and check it.
   task automatic issue_op(input logic [2*P-1:0] data, input logic [P-1:0] b);
      int unsigned d;
      int unsigned bb;
      logic edz;
      logic eovf;
      int elat;
      int lat;
      d    = int'(data);
      bb   = int'(b);
      edz  = 1'b0;
      eovf = 1'b0;
      elat = P;
`ifdef SYSDIV_CHECK_EN
      if (bb == 0) begin
         edz = 1'b1; elat = 0;
         exp_a = '1; exp_c = data[P-1:0];
      end else if (d >= (bb << P)) begin
         eovf = 1'b1; elat = 0;
         exp_a = '1; exp_c = '0;
      end else begin
         exp_a = P'(d / bb); exp_c = P'(d % bb);
      end
`else
      exp_a = P'(d / bb);
      exp_c = P'(d % bb);
`endif
      check_eq("in_ready_idle", 32'(IN_READY), 32'd1);
      IN_VALID = 1'b1;
      DATA_IN  = data;
      B1       = b;
      @(posedge C); #1;
      IN_VALID = 1'b0;
      DATA_IN  = (2*P)'($urandom);
      B1       = P'($urandom);
      lat = 0;
      while (!OUT_VALID && lat < 40) begin
         @(posedge C); #1;
         lat++;
      end
      check_eq("latency", 32'(lat), 32'(elat));
      check_eq("a1", 32'(A1), 32'(exp_a));
      check_eq("c1", 32'(C1), 32'(exp_c));
      check_eq("dz", 32'(DZ), 32'(edz));
      check_eq("ovf", 32'(OVF), 32'(eovf));
      $display("op data=0x%h b=0x%h -> a1=0x%h c1=0x%h dz=%0d ovf=%0d lat=%0d",
               data, b, A1, C1, DZ, OVF, lat);
   endtask

   // Take the result, optionally with random backpressure, and check the return to idle.
   task automatic consume(input bit rand_ready);
      bit done;
      bit r;
      int guard;
      done  = 1'b0;
      guard = 0;
      while (!done) begin
         r = rand_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
         if (guard > 30) r = 1'b1;
         OUT_READY = r;
         @(posedge C); #1;
         guard++;
         if (r) done = 1'b1;
      end
      OUT_READY = 1'b0;
      check_eq("out_valid_drop", 32'(OUT_VALID), 32'd0);
      check_eq("in_ready_back", 32'(IN_READY), 32'd1);
      check_eq("a1_kept", 32'(A1), 32'(exp_a));
      check_eq("c1_kept", 32'(C1), 32'(exp_c));
      check_eq("dz_clr", 32'(DZ), 32'd0);
      check_eq("ovf_clr", 32'(OVF), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
      check_eq({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
      check_eq({tag, "_a1"}, 32'(A1), 32'd0);
      check_eq({tag, "_c1"}, 32'(C1), 32'd0);
      check_eq({tag, "_dz"}, 32'(DZ), 32'd0);
      check_eq({tag, "_ovf"}, 32'(OVF), 32'd0);
   endtask

   initial begin
      int stray;
      logic [P-1:0] ra;
      logic [P-1:0] rb;
      logic [P-1:0] rc;
      logic [2*P-1:0] rd;
      int kind;

      // Reset state
      #12;
      check_reset_outputs("reset");
      @(posedge C); #1;
      nR = 1'b1;
      @(posedge C); #1;

      // Directed cases
      issue_op(16'h0C11, 8'h3F); consume(1'b0);
      issue_op(16'hFEFF, 8'hFF); consume(1'b0);
      issue_op(16'h0000, 8'h01); consume(1'b0);
`ifdef SYSDIV_CHECK_EN
      issue_op(16'h1234, 8'h00); consume(1'b0);
      issue_op(16'h1000, 8'h10); consume(1'b0);
`endif

      // Backpressure: result held 20 cycles, new IN_VALID ignored
      issue_op(16'h0C11, 8'h3F);
      OUT_READY = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            IN_VALID = 1'b1;
            DATA_IN  = 16'h0001;
            B1       = 8'h01;
         end
         @(posedge C); #1;
         check_eq("bp_out_valid", 32'(OUT_VALID), 32'd1);
         check_eq("bp_in_ready", 32'(IN_READY), 32'd0);
         check_eq("bp_a1", 32'(A1), 32'h31);
         check_eq("bp_c1", 32'(C1), 32'h02);
      end
      IN_VALID = 1'b0;
      consume(1'b0);
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge C); #1;
         if (OUT_VALID) stray++;
      end
      check_eq("bp_no_ghost_op", 32'(stray), 32'd0);

      // Reset during CALC step 4
      IN_VALID = 1'b1;
      DATA_IN  = 16'h0C11;
      B1       = 8'h3F;
      @(posedge C); #1;
      IN_VALID = 1'b0;
      repeat (3) @(posedge C);
      #2;
      nR = 1'b0;
      #1;
      check_reset_outputs("midcalc_rst");
      @(negedge C);
      nR = 1'b1;
      @(posedge C); #1;
      check_eq("rst_in_ready", 32'(IN_READY), 32'd1);
      stray = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge C); #1;
         if (OUT_VALID) stray++;
      end
      check_eq("rst_no_out_valid", 32'(stray), 32'd0);
      issue_op(16'h0C11, 8'h3F); consume(1'b1);

      // Random sweep: DATA_IN = A*B + Cin with Cin < B
      for (int n = 0; n < 2000; n++) begin
         ra = P'($urandom);
         rb = P'($urandom_range(1, (1 << P) - 1));
         rc = P'($urandom_range(0, int'(rb) - 1));
         rd = (2*P)'(int'(ra) * int'(rb) + int'(rc));
         kind = $urandom_range(0, 9);
`ifdef SYSDIV_CHECK_EN
         if (kind == 0) begin
            rb = '0;
         end else if (kind == 1) begin
            rd = {P'($urandom_range(int'(rb), (1 << P) - 1)), P'($urandom)};
         end
`endif
         issue_op(rd, rb);
         consume(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
